// File: rtl/split_target_queued.sv
// Split-transaction bus target: writes complete in place, reads are snapshotted into an
// in-order queue and returned once their latency expires and the arbiter grants the bus.
module split_target_queued #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MEM_WIDTH    = 12,
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned QUEUE_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] target_addr_in,
  input  logic              target_addr_in_valid,
  input  logic [DATA_W-1:0] target_data_in,
  input  logic              target_data_in_valid,
  input  logic              target_rw,
  input  logic              split_grant,
  output logic              split_req,
  output logic [DATA_W-1:0] target_data_out,
  output logic              target_data_out_valid,
  output logic              target_ack,
  output logic              target_split_ack,
  output logic              target_ready
);

  localparam int unsigned PtrW     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW     = $clog2(READ_LATENCY + 1);
  localparam int unsigned MemDepth = 2 ** MEM_WIDTH;

  logic [DATA_W-1:0]    mem_q   [MemDepth];
  logic [DATA_W-1:0]    qdata_q [QUEUE_DEPTH];
  logic [CntW-1:0]      qcnt_q  [QUEUE_DEPTH];
  logic [PtrW-1:0]      head_q, tail_q;
  logic [PtrW:0]        count_q;
  logic                 wr_pend_q;
  logic [MEM_WIDTH-1:0] wr_idx_q;
  logic                 wack_q;
  logic                 ack_q, rd_ret_q, split_ack_q;
  logic [DATA_W-1:0]    dout_q;

  logic wr_now, accept, rd_acc, wr_acc, pop, wack_want;
  logic ack_d, wack_d;
  logic unused_addr_hi;

  assign unused_addr_hi = ^target_addr_in[ADDR_W-1:MEM_WIDTH];

  always_comb begin
    wr_now       = target_data_in_valid && wr_pend_q;
    // The data strobe of a pending write frees the port in that same cycle.
    target_ready = (count_q < (PtrW + 1)'(QUEUE_DEPTH)) && (!wr_pend_q || target_data_in_valid);
    accept       = target_addr_in_valid && target_ready;
    rd_acc       = accept && !target_rw;
    wr_acc       = accept && target_rw;
    split_req    = (count_q != '0) && (qcnt_q[head_q] == '0) && !rd_ret_q;
    pop          = split_req && split_grant;
    wack_want    = wr_now || wack_q;
    // A read return owns the ack pulse; a colliding write ack slips by one cycle.
    ack_d        = pop || wack_want;
    wack_d       = pop && wack_want;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= '0;
      wack_q      <= 1'b0;
      ack_q       <= 1'b0;
      rd_ret_q    <= 1'b0;
      split_ack_q <= 1'b0;
      dout_q      <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        qcnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        if (qcnt_q[i] != '0) begin
          qcnt_q[i] <= qcnt_q[i] - 1'b1;
        end
      end
      if (rd_acc) begin
        qcnt_q[tail_q] <= CntW'(READ_LATENCY);
        tail_q         <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
        dout_q <= qdata_q[head_q];
      end
      if (rd_acc && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!rd_acc && pop) begin
        count_q <= count_q - 1'b1;
      end
      if (wr_acc) begin
        wr_pend_q <= 1'b1;
        wr_idx_q  <= target_addr_in[MEM_WIDTH-1:0];
      end else if (wr_now) begin
        wr_pend_q <= 1'b0;
      end
      rd_ret_q    <= pop;
      split_ack_q <= rd_acc;
      ack_q       <= ack_d;
      wack_q      <= wack_d;
    end
  end

  // Storage is deliberately not reset; a same-cycle read snapshots the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_now) begin
      mem_q[wr_idx_q] <= target_data_in;
    end
    if (rd_acc) begin
      qdata_q[tail_q] <= mem_q[target_addr_in[MEM_WIDTH-1:0]];
    end
  end

  assign target_data_out       = dout_q;
  assign target_data_out_valid = rd_ret_q;
  assign target_ack            = ack_q;
  assign target_split_ack      = split_ack_q;

endmodule

// File: tb/tb_split_target_queued.sv
// Directed bench for split_target_queued: a per-cycle vector table plus hand-written
// sequences for snapshot ordering, ack collision and mid-operation reset.
module tb_split_target_queued;

  logic        clk;
  logic        rst_n;
  logic [15:0] target_addr_in;
  logic        target_addr_in_valid;
  logic [7:0]  target_data_in;
  logic        target_data_in_valid;
  logic        target_rw;
  logic        split_grant;
  logic        split_req;
  logic [7:0]  target_data_out;
  logic        target_data_out_valid;
  logic        target_ack;
  logic        target_split_ack;
  logic        target_ready;

  int errors = 0;
  int checks = 0;

  split_target_queued dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .target_addr_in       (target_addr_in),
    .target_addr_in_valid (target_addr_in_valid),
    .target_data_in       (target_data_in),
    .target_data_in_valid (target_data_in_valid),
    .target_rw            (target_rw),
    .split_grant          (split_grant),
    .split_req            (split_req),
    .target_data_out      (target_data_out),
    .target_data_out_valid(target_data_out_valid),
    .target_ack           (target_ack),
    .target_split_ack     (target_split_ack),
    .target_ready         (target_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One row: inputs driven for one cycle, outputs expected in the following idle cycle.
  typedef struct {
    logic        av;
    logic        rw;
    logic [15:0] addr;
    logic        dvi;
    logic [7:0]  din;
    logic        gnt;
    logic        sreq;
    logic        dov;
    logic [7:0]  dout;
    logic        ack;
    logic        sack;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic av, input logic rw, input logic [15:0] addr, input logic dvi,
                     input logic [7:0] din, input logic gnt, input logic sreq, input logic dov,
                     input logic [7:0] dout, input logic ack, input logic sack,
                     input logic rdy);
    vec_t v;
    v.av = av; v.rw = rw; v.addr = addr; v.dvi = dvi; v.din = din; v.gnt = gnt;
    v.sreq = sreq; v.dov = dov; v.dout = dout; v.ack = ack; v.sack = sack; v.rdy = rdy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    target_addr_in_valid = 1'b0;
    target_rw            = 1'b0;
    target_addr_in       = '0;
    target_data_in_valid = 1'b0;
    target_data_in       = '0;
    split_grant          = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic wait_req(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (split_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk({nm, "_req_seen"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_grant(input string nm, input logic [7:0] exp);
    wait_req(nm);
    split_grant = 1'b1;
    step();
    chk({nm, "_dv"}, {31'b0, target_data_out_valid}, 32'd1);
    chk({nm, "_dout"}, {24'b0, target_data_out}, {24'b0, exp});
    chk({nm, "_ack"}, {31'b0, target_ack}, 32'd1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    target_addr_in_valid = 1'b1; target_rw = 1'b1; target_addr_in = a;
    step();
    target_data_in_valid = 1'b1; target_data_in = d;
    step();
    chk("wr_ack", {31'b0, target_ack}, 32'd1);
  endtask

  task automatic do_read(input string nm, input logic [15:0] a, input logic [7:0] exp);
    target_addr_in_valid = 1'b1; target_rw = 1'b0; target_addr_in = a;
    step();
    chk({nm, "_sack"}, {31'b0, target_split_ack}, 32'd1);
    wait_grant(nm, exp);
  endtask

  initial begin
    bit bad;
    rst_n = 1'b0;
    idle_inputs();

    // Write 0xC5 to 0x8F20, read it back with grant two cycles after split_req.
    add(1, 1, 16'h8F20, 0, 8'h00, 0,  0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 8'hC5, 0,  0, 0, 8'h00, 1, 0, 1);
    add(1, 0, 16'h8F20, 0, 8'h00, 0,  0, 0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0, 0, 8'h0, 0,  0, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0, 0, 8'h0, 0,  1, 0, 8'h00, 0, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  0, 1, 8'hC5, 1, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 0,  0, 0, 8'hC5, 0, 0, 1);
    // Preload 0x010..0x013 with 0xA0..0xA3.
    for (int i = 0; i < 4; i++) begin
      add(1, 1, 16'h0010 + 16'(i), 0, 8'h00, 0,  0, 0, 8'hC5, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 8'hA0 + 8'(i), 0,  0, 0, 8'hC5, 1, 0, 1);
    end
    // Four back-to-back reads, grant held high.
    for (int i = 0; i < 4; i++)
      add(1, 0, 16'h0010 + 16'(i), 0, 8'h00, 1,  0, 0, 8'hC5, 0, 1, logic'(i < 3));
    add(0, 0, 16'h0000, 0, 8'h00, 1,  1, 0, 8'hC5, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 16'h0000, 0, 8'h00, 1,  0, 1, 8'hA0 + 8'(k), 1, 0, 1);
      if (k < 3) add(0, 0, 16'h0000, 0, 8'h00, 1,  1, 0, 8'hA0 + 8'(k), 0, 0, 1);
    end
    add(0, 0, 16'h0000, 0, 8'h00, 0,  0, 0, 8'hA3, 0, 0, 1);
    // Fill the queue, strobe a fifth read while full, pop one, retry.
    for (int i = 0; i < 4; i++)
      add(1, 0, 16'h0010 + 16'(i), 0, 8'h00, 0,  0, 0, 8'hA3, 0, 1, logic'(i < 3));
    add(1, 0, 16'h8F20, 0, 8'h00, 0,  1, 0, 8'hA3, 0, 0, 0);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  0, 1, 8'hA0, 1, 0, 1);
    add(1, 0, 16'h8F20, 0, 8'h00, 0,  1, 0, 8'hA0, 0, 1, 0);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  0, 1, 8'hA1, 1, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  1, 0, 8'hA1, 0, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  0, 1, 8'hA2, 1, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  1, 0, 8'hA2, 0, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  0, 1, 8'hA3, 1, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  1, 0, 8'hA3, 0, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 1,  0, 1, 8'hC5, 1, 0, 1);
    add(0, 0, 16'h0000, 0, 8'h00, 0,  0, 0, 8'hC5, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sreq", {31'b0, split_req}, 32'd0);
    chk("rst_dv", {31'b0, target_data_out_valid}, 32'd0);
    chk("rst_dout", {24'b0, target_data_out}, 32'd0);
    chk("rst_ack", {31'b0, target_ack}, 32'd0);
    chk("rst_sack", {31'b0, target_split_ack}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'b0, target_ready}, 32'd1);

    foreach (tbl[r]) begin
      target_addr_in_valid = tbl[r].av;
      target_rw            = tbl[r].rw;
      target_addr_in       = tbl[r].addr;
      target_data_in_valid = tbl[r].dvi;
      target_data_in       = tbl[r].din;
      split_grant          = tbl[r].gnt;
      step();
      chk($sformatf("row%0d_sreq", r), {31'b0, split_req}, {31'b0, tbl[r].sreq});
      chk($sformatf("row%0d_dv", r), {31'b0, target_data_out_valid}, {31'b0, tbl[r].dov});
      chk($sformatf("row%0d_dout", r), {24'b0, target_data_out}, {24'b0, tbl[r].dout});
      chk($sformatf("row%0d_ack", r), {31'b0, target_ack}, {31'b0, tbl[r].ack});
      chk($sformatf("row%0d_sack", r), {31'b0, target_split_ack}, {31'b0, tbl[r].sack});
      chk($sformatf("row%0d_rdy", r), {31'b0, target_ready}, {31'b0, tbl[r].rdy});
    end

    // Read and write data strobe to the same index in one cycle: read sees the old word.
    do_write(16'h0020, 8'h11);
    target_addr_in_valid = 1'b1; target_rw = 1'b1; target_addr_in = 16'h0020;
    step();
    chk("same_wr_pend_ready", {31'b0, target_ready}, 32'd0);
    target_addr_in_valid = 1'b1; target_rw = 1'b0; target_addr_in = 16'h0020;
    target_data_in_valid = 1'b1; target_data_in = 8'h55;
    step();
    chk("same_wr_ack", {31'b0, target_ack}, 32'd1);
    chk("same_rd_sack", {31'b0, target_split_ack}, 32'd1);
    wait_grant("same_old", 8'h11);
    do_read("same_new", 16'h0020, 8'h55);

    // Write data arrives in the cycle a read return is granted: write ack slips one cycle.
    target_addr_in_valid = 1'b1; target_rw = 1'b0; target_addr_in = 16'h0010;
    step();
    chk("coll_sack", {31'b0, target_split_ack}, 32'd1);
    target_addr_in_valid = 1'b1; target_rw = 1'b1; target_addr_in = 16'h0030;
    step();
    chk("coll_wr_pend_ready", {31'b0, target_ready}, 32'd0);
    wait_req("coll");
    split_grant = 1'b1; target_data_in_valid = 1'b1; target_data_in = 8'h77;
    step();
    chk("coll_rd_dv", {31'b0, target_data_out_valid}, 32'd1);
    chk("coll_rd_ack", {31'b0, target_ack}, 32'd1);
    chk("coll_rd_dout", {24'b0, target_data_out}, 32'hA0);
    step();
    chk("coll_wr_dv", {31'b0, target_data_out_valid}, 32'd0);
    chk("coll_wr_ack", {31'b0, target_ack}, 32'd1);
    step();
    chk("coll_after_ack", {31'b0, target_ack}, 32'd0);
    do_read("coll_wdata", 16'h0030, 8'h77);

    // Reset with three reads outstanding.
    for (int i = 0; i < 3; i++) begin
      target_addr_in_valid = 1'b1; target_rw = 1'b0; target_addr_in = 16'h0010 + 16'(i);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_sreq", {31'b0, split_req}, 32'd0);
    chk("mrst_dv", {31'b0, target_data_out_valid}, 32'd0);
    chk("mrst_dout", {24'b0, target_data_out}, 32'd0);
    chk("mrst_ack", {31'b0, target_ack}, 32'd0);
    chk("mrst_sack", {31'b0, target_split_ack}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("mrst_ready", {31'b0, target_ready}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      split_grant = 1'b1;
      step();
      if (split_req || target_ack || target_split_ack || target_data_out_valid) bad = 1'b1;
    end
    chk("mrst_quiet", {31'b0, bad}, 32'd0);
    do_read("mrst_mem_kept", 16'h0011, 8'hA1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
